// File: rtl/fc_layer_seq.sv
// Sequential fully-connected layer: one input element per MAC cycle, all outputs in parallel.
// Optional macro FC_SEQ_RELU_EN clamps negative saturated outputs to zero.
module fc_layer_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_NODES   = 4,
    parameter int OUT_NODES  = 4,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(IN_NODES) + 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [DATA_WIDTH*IN_NODES-1:0]           input_vector,
    input  logic [DATA_WIDTH*IN_NODES*OUT_NODES-1:0] weight_vector,
    input  logic [DATA_WIDTH*OUT_NODES-1:0]          bias_vector,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [DATA_WIDTH*OUT_NODES-1:0]          output_vector
);
    localparam int IW = $clog2(IN_NODES + 1);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                                          state_q;
    logic [IW-1:0]                                   i_q;
    logic                                            in_ready_q, out_valid_q;
    logic [IN_NODES-1:0][DATA_WIDTH-1:0]             x_q;
    logic [IN_NODES*OUT_NODES-1:0][DATA_WIDTH-1:0]   w_q;
    logic signed [ACC_WIDTH-1:0]                     acc_q [OUT_NODES];
    logic [OUT_NODES-1:0][DATA_WIDTH-1:0]            out_q;

    logic signed [DATA_WIDTH-1:0]                    x_sel;
    logic signed [DATA_WIDTH-1:0]                    w_sel [OUT_NODES];
    logic signed [2*DATA_WIDTH-1:0]                  prod  [OUT_NODES];
    logic [ACC_WIDTH-DATA_WIDTH:0]                   hi    [OUT_NODES];
    logic [OUT_NODES-1:0][DATA_WIDTH-1:0]            y_d;

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign output_vector = out_q;

    always_comb begin
        x_sel = '0;
        for (int j = 0; j < OUT_NODES; j++) w_sel[j] = '0;
        for (int k = 0; k < IN_NODES; k++) begin
            if (i_q == IW'(k)) begin
                x_sel = signed'(x_q[k]);
                for (int j = 0; j < OUT_NODES; j++) w_sel[j] = signed'(w_q[k*OUT_NODES+j]);
            end
        end
        for (int j = 0; j < OUT_NODES; j++) begin
            prod[j] = (2*DATA_WIDTH)'(x_sel) * (2*DATA_WIDTH)'(w_sel[j]);
            // Value fits in DATA_WIDTH only when all bits above the output sign bit agree.
            hi[j] = acc_q[j][ACC_WIDTH-1:DATA_WIDTH-1];
            if (&hi[j] || ~|hi[j])
                y_d[j] = acc_q[j][DATA_WIDTH-1:0];
            else if (acc_q[j][ACC_WIDTH-1])
                y_d[j] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            else
                y_d[j] = {1'b0, {(DATA_WIDTH-1){1'b1}}};
`ifdef FC_SEQ_RELU_EN
            if (y_d[j][DATA_WIDTH-1]) y_d[j] = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            i_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            x_q         <= '0;
            w_q         <= '0;
            out_q       <= '0;
            for (int j = 0; j < OUT_NODES; j++) acc_q[j] <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    x_q        <= input_vector;
                    w_q        <= weight_vector;
                    i_q        <= '0;
                    in_ready_q <= 1'b0;
                    state_q    <= MAC;
                    for (int j = 0; j < OUT_NODES; j++)
                        acc_q[j] <= ACC_WIDTH'(signed'(bias_vector[j*DATA_WIDTH +: DATA_WIDTH]));
                end
                MAC: begin
                    // Final pass commits the saturated accumulators once all products are in.
                    if (i_q == IW'(IN_NODES)) begin
                        out_q       <= y_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        for (int j = 0; j < OUT_NODES; j++)
                            acc_q[j] <= acc_q[j] + ACC_WIDTH'(prod[j]);
                        i_q <= i_q + IW'(1);
                    end
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
